// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard scheduler for a 5-stage RV32I pipeline. It produces per-stage stall
// and flush enables, EX operand-forwarding selects, a memory-wait FSM with a
// timeout error state, and two saturating performance counters.
// Stage vectors are ordered {F, D, E, M, W}.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [1:0]       RegReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [2:0]       RegWriteE,
  input  logic [2:0]       RegWriteM,
  input  logic [2:0]       RegWriteW,
  input  logic             MemToRegE,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  localparam logic [15:0]      TMO     = MEM_TIMEOUT[15:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic             memerr_q, memerr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             memblk_s, redirect_s, loaduse_s, hold_s;
  logic [4:0]       stall_s, flush_s;

  // Forward select for one EX operand; MEM beats WB, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic       use_i,
                                         input logic [4:0] rs_i,
                                         input logic [2:0] wm_i,
                                         input logic [4:0] rdm_i,
                                         input logic [2:0] ww_i,
                                         input logic [4:0] rdw_i);
    logic [1:0] sel;
    if (use_i && (rs_i != 5'd0) && (wm_i != 3'b000) && (rdm_i == rs_i)) begin
      sel = 2'b10;
    end else if (use_i && (rs_i != 5'd0) && (ww_i != 3'b000) && (rdw_i == rs_i)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign memblk_s   = MemReqM & ~MemAckM;
  assign redirect_s = BranchE | JalrE;
  assign loaduse_s  = MemToRegE & (RegWriteE != 3'b000) & (RdE != 5'd0) &
                      ((RegReadD[1] & (Rs1D == RdE)) | (RegReadD[0] & (Rs2D == RdE)));

  // Stall/flush priority: reset, error, memory block, redirect, load-use, jal.
  always_comb begin
    stall_s = 5'b00000;
    flush_s = 5'b00000;
    hold_s  = 1'b0;
    if (CPU_RST) begin
      flush_s = 5'b11111;
    end else if (state_q == ST_ERR) begin
      stall_s = 5'b11111;
    end else begin
      // While waiting, only the ack releases the pipeline.
      if (state_q == ST_WAIT) begin
        hold_s = ~MemAckM;
      end else begin
        hold_s = memblk_s;
      end
      if (hold_s) begin
        stall_s = 5'b11110;
        flush_s = 5'b00001;
      end else if (redirect_s) begin
        flush_s = 5'b01100;
      end else if (loaduse_s) begin
        stall_s = 5'b11000;
        flush_s = 5'b00100;
      end else if (JalD) begin
        flush_s = 5'b01000;
      end else begin
        stall_s = 5'b00000;
        flush_s = 5'b00000;
      end
    end
  end

  // Memory-wait FSM next state, wait counter and sticky error flag.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memerr_d = memerr_q;
    case (state_q)
      ST_RUN: begin
        if (memblk_s) begin
          state_d = ST_WAIT;
          wcnt_d  = 16'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (MemAckM) begin
          state_d = ST_RUN;
        end else if (wcnt_q == TMO) begin
          state_d  = ST_ERR;
          memerr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        memerr_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating counters of StallF and FlushD cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s[4] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s[3] && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State register with synchronous reset that aborts any wait or error.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q     <= ST_RUN;
      wcnt_q      <= 16'd0;
      memerr_q    <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      memerr_q    <= memerr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign {StallF, StallD, StallE, StallM, StallW} = stall_s;
  assign {FlushF, FlushD, FlushE, FlushM, FlushW} = flush_s;
  assign Forward1E = CPU_RST ? 2'b00 : fwd_sel(RegReadE[1], Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign Forward2E = CPU_RST ? 2'b00 : fwd_sel(RegReadE[0], Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  assign MemErr    = memerr_q & ~CPU_RST;
  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CPU_CLK = 1'b0;
  logic          CPU_RST = 1'b1;
  logic [4:0]    Rs1D = 5'd0, Rs2D = 5'd0, Rs1E = 5'd0, Rs2E = 5'd0;
  logic [4:0]    RdE = 5'd0, RdM = 5'd0, RdW = 5'd0;
  logic [1:0]    RegReadD = 2'b00, RegReadE = 2'b00;
  logic [2:0]    RegWriteE = 3'b000, RegWriteM = 3'b000, RegWriteW = 3'b000;
  logic          MemToRegE = 1'b0, BranchE = 1'b0, JalrE = 1'b0, JalD = 1'b0;
  logic          MemReqM = 1'b0, MemAckM = 1'b0;
  logic          StallF, StallD, StallE, StallM, StallW;
  logic          FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    Forward1E, Forward2E;
  logic          MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  int checks = 0;
  int errors = 0;

  // Model state: cycles spent waiting (0 = not waiting), error flag, counters.
  int m_wait = 0;
  bit m_err  = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RegReadE(RegReadE),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_model(input bit used, input int rs);
    if (!used || rs == 0) return 0;
    if (RegWriteM != 0 && int'(RdM) == rs) return 2;
    if (RegWriteW != 0 && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  // Expected outputs from the current inputs and the model state.
  function automatic void expect_now(output logic [4:0] st, output logic [4:0] fl,
                                     output logic [1:0] f1, output logic [1:0] f2,
                                     output logic me);
    bit blocked, loaduse;
    st = 5'b00000; fl = 5'b00000; f1 = 2'b00; f2 = 2'b00; me = 1'b0;
    if (CPU_RST) begin
      fl = 5'b11111;
      return;
    end
    f1 = 2'(fwd_model(RegReadE[1], int'(Rs1E)));
    f2 = 2'(fwd_model(RegReadE[0], int'(Rs2E)));
    me = m_err;
    if (m_err) begin
      st = 5'b11111;
      return;
    end
    blocked = (m_wait > 0) ? !MemAckM : (MemReqM && !MemAckM);
    loaduse = MemToRegE && RegWriteE != 0 && RdE != 0 &&
              ((RegReadD[1] && Rs1D == RdE) || (RegReadD[0] && Rs2D == RdE));
    if (blocked) begin st = 5'b11110; fl = 5'b00001; end
    else if (BranchE || JalrE) fl = 5'b01100;
    else if (loaduse) begin st = 5'b11000; fl = 5'b00100; end
    else if (JalD) fl = 5'b01000;
  endfunction

  // Model update on each rising edge, compare on each falling edge.
  initial begin
    logic [4:0] st, fl;
    logic [1:0] f1, f2;
    logic me;
    forever begin
      @(posedge CPU_CLK);
      expect_now(st, fl, f1, f2, me);
      if (CPU_RST) begin
        m_wait = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
      end else begin
        if (st[4] && m_scnt < CMAX) m_scnt++;
        if (fl[3] && m_fcnt < CMAX) m_fcnt++;
        if (m_err) begin
        end else if (m_wait == 0) begin
          if (MemReqM && !MemAckM) m_wait = 1;
        end else if (MemAckM) begin
          m_wait = 0;
        end else if (m_wait == TMO) begin
          m_err = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      @(negedge CPU_CLK);
      expect_now(st, fl, f1, f2, me);
      chk("model_stall", {27'd0, StallF, StallD, StallE, StallM, StallW}, {27'd0, st});
      chk("model_flush", {27'd0, FlushF, FlushD, FlushE, FlushM, FlushW}, {27'd0, fl});
      chk("model_fwd1", {30'd0, Forward1E}, {30'd0, f1});
      chk("model_fwd2", {30'd0, Forward2E}, {30'd0, f2});
      chk("model_memerr", {31'd0, MemErr}, {31'd0, me});
      chk("model_stallcnt", 32'(StallCnt), 32'(m_scnt));
      chk("model_flushcnt", 32'(FlushCnt), 32'(m_fcnt));
    end
  end

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CPU_CLK);
  endtask

  task automatic chk_sf(input string name, input logic [4:0] st, input logic [4:0] fl);
    chk({name, "_stall"}, {27'd0, StallF, StallD, StallE, StallM, StallW}, {27'd0, st});
    chk({name, "_flush"}, {27'd0, FlushF, FlushD, FlushE, FlushM, FlushW}, {27'd0, fl});
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegReadD = 2'b00; RegReadE = 2'b00;
    RegWriteE = 3'b000; RegWriteM = 3'b000; RegWriteW = 3'b000;
    MemToRegE = 1'b0; BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  task automatic set_loaduse();
    RdE = 5'd5; MemToRegE = 1'b1; RegWriteE = 3'b011;
    Rs1D = 5'd5; RegReadD = 2'b10;
  endtask

  initial begin
    // Reset state.
    settle();
    chk_sf("reset", 5'b00000, 5'b11111);
    chk("reset_memerr", {31'd0, MemErr}, 32'd0);
    chk("reset_stallcnt", 32'(StallCnt), 32'd0);
    step(); CPU_RST = 1'b0;
    settle();
    chk_sf("idle", 5'b00000, 5'b00000);

    // Load-use: one bubble, then clear once the load has moved on.
    step(); set_loaduse();
    settle();
    chk_sf("loaduse", 5'b11000, 5'b00100);
    step(); MemToRegE = 1'b0; RegWriteE = 3'b000; RdE = 5'd0;
    settle();
    chk_sf("loaduse_after", 5'b00000, 5'b00000);
    chk("loaduse_stallcnt", 32'(StallCnt), 32'd1);

    // Forwarding priority and x0.
    step(); clear_inputs();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 3'b001; RegWriteW = 3'b001;
    Rs1E = 5'd7; RegReadE = 2'b10;
    settle();
    chk("fwd_mem", {30'd0, Forward1E}, 32'd2);
    chk("fwd_rs2_unused", {30'd0, Forward2E}, 32'd0);
    step(); RdM = 5'd0;
    settle();
    chk("fwd_wb", {30'd0, Forward1E}, 32'd1);
    step(); Rs1E = 5'd0;
    settle();
    chk("fwd_x0", {30'd0, Forward1E}, 32'd0);

    // Branch beats load-use.
    step(); clear_inputs(); set_loaduse(); BranchE = 1'b1;
    settle();
    chk_sf("branch", 5'b00000, 5'b01100);
    chk("branch_flushcnt_before", 32'(FlushCnt), 32'd0);
    step(); clear_inputs();
    settle();
    chk("branch_flushcnt_after", 32'(FlushCnt), 32'd1);

    // Memory access acked three cycles after the request.
    step(); MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_sf("memwait", 5'b11110, 5'b00001);
      step();
    end
    MemAckM = 1'b1;
    settle();
    chk_sf("memack", 5'b00000, 5'b00000);
    step(); MemReqM = 1'b0; MemAckM = 1'b0;
    settle();
    chk_sf("mem_run", 5'b00000, 5'b00000);
    chk("mem_stallcnt", 32'(StallCnt), 32'd4);

    // Timeout: request cycle plus four un-acked waits, then ERR.
    step(); MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_sf("pre_timeout", 5'b11110, 5'b00001);
      chk("pre_timeout_memerr", {31'd0, MemErr}, 32'd0);
      step();
    end
    settle();
    chk_sf("err", 5'b11111, 5'b00000);
    chk("err_memerr", {31'd0, MemErr}, 32'd1);
    step(); MemReqM = 1'b0; MemAckM = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      chk("err_sticky", {31'd0, MemErr}, 32'd1);
      chk("err_stallw", {31'd0, StallW}, 32'd1);
      step();
    end
    settle();
    chk("stallcnt_saturated", 32'(StallCnt), 32'hF);
    step(); clear_inputs(); CPU_RST = 1'b1;
    settle();
    chk_sf("err_reset", 5'b00000, 5'b11111);
    chk("err_reset_memerr", {31'd0, MemErr}, 32'd0);
    step(); CPU_RST = 1'b0;
    settle();
    chk("post_reset_stallcnt", 32'(StallCnt), 32'd0);
    chk("post_reset_flushcnt", 32'(FlushCnt), 32'd0);
    chk("post_reset_memerr", {31'd0, MemErr}, 32'd0);

    // Randomized traffic with small index ranges to force collisions.
    for (int n = 0; n < 3000; n++) begin
      step();
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      RegReadD = 2'($urandom); RegReadE = 2'($urandom);
      RegWriteE = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      RegWriteM = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      RegWriteW = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      MemToRegE = 1'($urandom_range(0, 1));
      BranchE = ($urandom_range(0, 7) == 0);
      JalrE = ($urandom_range(0, 15) == 0);
      JalD = ($urandom_range(0, 7) == 0);
      MemReqM = ($urandom_range(0, 3) == 0);
      MemAckM = ($urandom_range(0, 3) != 0);
      CPU_RST = ($urandom_range(0, 149) == 0);
    end
    step();
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
